// File: rtl/mram_serial_cmd_driver.sv
// mram_serial_cmd_driver
// Accepts one parallel MRAM command over a valid/ready handshake and turns it
// into the serial data_in / addr_in / read_write_sel frame of the MRAM top
// module. Reads are deserialised back into a response word. Between frames
// the top module is parked by holding its reset (mram_rst) high.
//
// Build option: define MRAM_DRV_RDMASK_EN to zero the byte lanes of the read
// response that were not selected by the command byte enables.
module mram_serial_cmd_driver #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int READ_LAT   = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_be,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ser_data,
  output logic              ser_addr,
  output logic [2:0]        rw_sel,
  output logic              mram_rst,
  input  logic              ser_rdata,
  output logic              busy
);

  // One shared down-phase counter covers the longest of the timed phases.
  localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_LG  = (READ_LAT > GAP_CYCLES) ? READ_LAT : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_AD > MAX_LG) ? MAX_AD : MAX_LG;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int LO_W    = DATA_W / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_RESP,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_sh_q;
  logic [DATA_W-1:0]   wdata_sh_q;
  logic                write_q;
  logic [DATA_W-1:0]   rdata_sh_q;
  logic                ser_rdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                ser_data_q;
  logic                ser_addr_q;
  logic [2:0]          rw_sel_q;
  logic                mram_rst_q;
  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   rsp_word_d;

`ifdef MRAM_DRV_RDMASK_EN
  logic [1:0]          be_q;

  // Lower half of the word follows be[0], upper half follows be[1].
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_lane_mask
    if (gi < LO_W) begin : g_lo
      assign lane_mask[gi] = be_q[0];
    end else begin : g_hi
      assign lane_mask[gi] = be_q[1];
    end
  end
`else
  assign lane_mask = '1;
`endif

  // Final response word: shift register plus the last pending sample, masked.
  always_comb begin
    rsp_word_d = {rdata_sh_q[DATA_W-2:0], ser_rdata_q} & lane_mask;
  end

  // Input flop on the serial read line; the shift register consumes its
  // output one cycle later, which keeps the capture window aligned with the
  // edge where the first bit is actually sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_rdata_q <= 1'b0;
    end else begin
      ser_rdata_q <= ser_rdata;
    end
  end

  // Command sequencer: state, phase counter, shift registers and all
  // registered outputs move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      write_q     <= 1'b0;
`ifdef MRAM_DRV_RDMASK_EN
      be_q        <= 2'b00;
`endif
      rdata_sh_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ser_data_q  <= 1'b0;
      ser_addr_q  <= 1'b0;
      rw_sel_q    <= 3'b000;
      mram_rst_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            write_q    <= cmd_write;
`ifdef MRAM_DRV_RDMASK_EN
            be_q       <= cmd_be;
`endif
            addr_sh_q  <= cmd_addr;
            wdata_sh_q <= cmd_write ? cmd_wdata : '0;
            cnt_q      <= '0;
            if (cmd_be == 2'b00) begin
              // Nothing to frame: writes just observe the gap, reads answer zero.
              if (cmd_write) begin
                state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
              end else begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
              end
            end else begin
              state_q    <= S_SETUP;
              rw_sel_q   <= {cmd_be, cmd_write};
              mram_rst_q <= 1'b0;
              ser_data_q <= 1'b0;
              ser_addr_q <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          state_q    <= S_SHIFT;
          cnt_q      <= '0;
          ser_addr_q <= addr_sh_q[0];
          ser_data_q <= wdata_sh_q[0];
          addr_sh_q  <= addr_sh_q >> 1;
          wdata_sh_q <= wdata_sh_q >> 1;
        end

        S_SHIFT: begin
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_q      <= '0;
            ser_addr_q <= 1'b0;
            ser_data_q <= 1'b0;
            if (write_q) begin
              rw_sel_q   <= 3'b000;
              mram_rst_q <= 1'b1;
              state_q    <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end else begin
              state_q <= (READ_LAT == 0) ? S_CAPTURE : S_WAIT;
            end
          end else begin
            // Write data runs out after DATA_W bits because the register
            // back-fills with zeros.
            cnt_q      <= cnt_q + CNT_W'(1);
            ser_addr_q <= addr_sh_q[0];
            ser_data_q <= wdata_sh_q[0];
            addr_sh_q  <= addr_sh_q >> 1;
            wdata_sh_q <= wdata_sh_q >> 1;
          end
        end

        S_WAIT: begin
          if (cnt_q == CNT_W'(READ_LAT - 1)) begin
            cnt_q   <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          rdata_sh_q <= {rdata_sh_q[DATA_W-2:0], ser_rdata_q};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q       <= '0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_word_d;
            rw_sel_q    <= 3'b000;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            mram_rst_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end

        S_GAP: begin
          mram_rst_q <= 1'b1;
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q    <= S_IDLE;
          rw_sel_q   <= 3'b000;
          mram_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ser_data  = ser_data_q;
  assign ser_addr  = ser_addr_q;
  assign rw_sel    = rw_sel_q;
  assign mram_rst  = mram_rst_q;

endmodule

// File: tb/tb_mram_serial_cmd_driver.sv
// Bench for mram_serial_cmd_driver: directed and random commands, each
// checked cycle by cycle against a timeline model derived from the frame
// timing (accept edge T0, setup, 20 address bits, latency, capture, gap).
module tb_mram_serial_cmd_driver;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int RL  = 2;
  localparam int GAP = 2;

  localparam int PH_SETUP = 0;
  localparam int PH_SHIFT = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_RESP  = 3;
  localparam int PH_GAP   = 4;
  localparam int PH_DONE  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [1:0]    cmd_be;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ser_data;
  logic          ser_addr;
  logic [2:0]    rw_sel;
  logic          mram_rst;
  logic          ser_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  mram_serial_cmd_driver #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_be(cmd_be), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ser_data(ser_data), .ser_addr(ser_addr), .rw_sel(rw_sel),
    .mram_rst(mram_rst), .ser_rdata(ser_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (txn %0d, time %0t)", tag, obs, exp, txn, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_rdy"},  cmd_ready, 1);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_rv"},   rsp_valid, 0);
    check_val({pfx, "_rw"},   rw_sel, 0);
    check_val({pfx, "_mr"},   mram_rst, 1);
    check_val({pfx, "_sa"},   ser_addr, 0);
    check_val({pfx, "_sd"},   ser_data, 0);
  endtask

  // Expected read response from the command's byte enables.
  function automatic logic [DW-1:0] model_rdata(input logic [1:0] be, input logic [DW-1:0] rv);
    logic [DW-1:0] m;
    if (be == 2'b00) return '0;
`ifdef MRAM_DRV_RDMASK_EN
    m = {{(DW/2){be[1]}}, {(DW/2){be[0]}}};
`else
    m = '1;
`endif
    return rv & m;
  endfunction

  // Issue one command and follow it to IDLE. rv is the word the loopback
  // memory returns; hold is the number of RESP cycles before rsp_ready;
  // rst_at >= 0 pulses rst at that cycle index instead of completing.
  task automatic run_cmd(input logic wr, input logic [1:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                         input int hold, input int rst_at);
    int t, rstart, th, ph, k;
    bit fin;
    logic [DW-1:0] exp_rd;
    logic [2:0] frame_rw;
    logic e_sa, e_sd;

    txn++;
    check_val("pre_rdy", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_be = be; cmd_addr = addr; cmd_wdata = wd;
    rsp_ready = 1'b0;
    tick();
    exp_rd   = model_rdata(be, rv);
    frame_rw = {be, wr};
    rstart   = (be == 2'b00) ? 0 : (AW + 1 + RL + DW);
    th = -1; t = 0; fin = 0;
    while (!fin) begin
      if (t == rst_at) begin
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        check_val("arst_rd", rsp_rdata, 0);
        tick();
        rst = 1'b0;
        check_idle_outputs("arst2");
        fin = 1;
      end else if (t > 400) begin
        check_val("timeout", t, 0);
        cmd_valid = 1'b0;
        fin = 1;
      end else begin
        // Locate this cycle on the command timeline.
        if (wr) begin
          if (be == 2'b00) ph = (t < GAP) ? PH_GAP : PH_DONE;
          else if (t == 0) ph = PH_SETUP;
          else if (t <= AW) ph = PH_SHIFT;
          else if (t <= AW + GAP) ph = PH_GAP;
          else ph = PH_DONE;
        end else if (th < 0) begin
          if (t >= rstart) ph = PH_RESP;
          else if (t == 0) ph = PH_SETUP;
          else if (t <= AW) ph = PH_SHIFT;
          else ph = PH_HOLD;
        end else begin
          ph = (t < th + GAP) ? PH_GAP : PH_DONE;
        end

        e_sa = 1'b0; e_sd = 1'b0;
        if (ph == PH_SHIFT) begin
          k = t - 1;
          e_sa = addr[k];
          e_sd = (wr && k < DW) ? wd[k] : 1'b0;
        end

        if (ph == PH_DONE) begin
          check_idle_outputs("done");
          cmd_valid = 1'b0;
          fin = 1;
        end else begin
          check_val("rdy",  cmd_ready, 0);
          check_val("busy", busy, 1);
          check_val("rv",   rsp_valid, (ph == PH_RESP) ? 1 : 0);
          check_val("rw",   rw_sel, (ph == PH_SETUP || ph == PH_SHIFT || ph == PH_HOLD) ? frame_rw : 3'b000);
          if (ph != PH_RESP)
            check_val("mr", mram_rst, (ph == PH_GAP) ? 1 : 0);
          check_val("sa", ser_addr, e_sa);
          check_val("sd", ser_data, e_sd);
          if (ph == PH_RESP) begin
            check_val("rdata", rsp_rdata, exp_rd);
            rsp_ready = ((t - rstart) >= hold);
            if (rsp_ready) th = t + 1;
          end else begin
            rsp_ready = 1'($urandom_range(0, 1));
          end
          // Junk on the command bus must be ignored while busy.
          cmd_valid = 1'($urandom_range(0, 1));
          cmd_write = 1'($urandom_range(0, 1));
          cmd_be    = 2'($urandom_range(0, 3));
          cmd_addr  = AW'($urandom);
          cmd_wdata = DW'($urandom);
          // Loopback memory: bit DW-1-i is presented so it is sampled at
          // edge T(AW+1+RL+i); other cycles carry noise.
          if (!wr && be != 2'b00 && t >= AW + RL && t < AW + RL + DW)
            ser_rdata = rv[DW - 1 - (t - AW - RL)];
          else
            ser_rdata = 1'($urandom_range(0, 1));
          tick();
          t++;
        end
      end
    end
    rsp_ready = 1'b0;
    $display("txn %0d wr=%0b be=%02b addr=%05h wdata=%04h rdval=%04h hold=%0d rst_at=%0d cycles=%0d",
             txn, wr, be, addr, wd, rv, hold, rst_at, t);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_be = 2'b00;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; ser_rdata = 1'b0;
    tick(); tick(); tick();
    check_idle_outputs("reset");
    check_val("reset_rd", rsp_rdata, 0);
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Directed cases from the frame timing description.
    run_cmd(1'b1, 2'b11, 20'h00000, 16'hAAAA, 16'h0000, 0, -1);
    run_cmd(1'b1, 2'b01, 20'h00001, 16'h5555, 16'h0000, 0, -1);
    run_cmd(1'b0, 2'b11, 20'h12345, 16'h0000, 16'hBEEF, 0, -1);
    run_cmd(1'b0, 2'b10, 20'h0ABCD, 16'h0000, 16'hBEEF, 0, -1);
    run_cmd(1'b0, 2'b01, 20'hFFFFF, 16'h0000, 16'hBEEF, 0, -1);
    run_cmd(1'b0, 2'b11, 20'h54321, 16'h0000, 16'hC3A5, 10, -1);
    run_cmd(1'b1, 2'b00, 20'h11111, 16'hFFFF, 16'h0000, 0, -1);
    run_cmd(1'b0, 2'b00, 20'h22222, 16'h0000, 16'hFFFF, 3, -1);
    // Reset mid-SHIFT, then a normal command.
    run_cmd(1'b1, 2'b11, 20'hFFFFF, 16'hFFFF, 16'h0000, 0, 9);
    run_cmd(1'b1, 2'b11, 20'h80001, 16'h8001, 16'h0000, 0, -1);
    // Reset while a response is pending, then a normal read.
    run_cmd(1'b0, 2'b11, 20'h33333, 16'h0000, 16'h1234, 20, 42);
    run_cmd(1'b0, 2'b11, 20'h44444, 16'h0000, 16'h8421, 0, -1);

    // Random commands.
    for (int i = 0; i < 24; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom),
              DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), -1);
      for (int j = int'($urandom_range(0, 2)); j > 0; j--) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
